// File: rtl/pipe_stage_buf.sv
// Parametrised CPU pipeline stage register with a valid/ready handshake and synchronous flush.
// An optional skid entry registers in_ready. A saturating counter records stall cycles.
module pipe_stage_buf #(
    parameter int DATA_W   = 108,
    parameter int CTRL_W   = 8,
    parameter int SKID     = 1,
    parameter int CLR_DATA = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam bit SKID_EN = (SKID != 0);
    localparam bit CLR_EN  = (CLR_DATA != 0);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FULL    = 2'd1,
        ST_SKIDDED = 2'd2
    } state_t;

    state_t             state_p0;
    state_t             state_nxt;
    logic               vld_p0;
    logic [CTRL_W-1:0]  ctrl_p0;
    logic [DATA_W-1:0]  data_p0;
    logic [CTRL_W-1:0]  skid_ctrl_p1;
    logic [DATA_W-1:0]  skid_data_p1;
    logic [CNT_W-1:0]   stall_p0;

    logic in_fire;
    logic out_fire;
    logic load_in;
    logic load_skid;
    logic take_skid;
    logic clear_main;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    generate
        if (SKID_EN) begin : g_rdy_reg
            logic rdy_p0;
            // Ready is decoded from the next state so upstream never sees out_ready combinationally.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdy_p0 <= 1'b1;
                end else begin
                    rdy_p0 <= (state_nxt != ST_SKIDDED);
                end
            end
            assign in_ready = rdy_p0;
        end else begin : g_rdy_comb
            assign in_ready = !vld_p0 || out_ready;
        end
    endgenerate

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = vld_p0 && out_ready;
    assign out_valid = vld_p0;
    assign out_ctrl  = ctrl_p0;
    assign out_data  = data_p0;
    assign stall_cnt = stall_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p0 <= ST_EMPTY;
            vld_p0   <= 1'b0;
        end else begin
            state_p0 <= state_nxt;
            vld_p0   <= (state_nxt != ST_EMPTY);
        end
    end

    always_comb begin
        state_nxt = state_p0;
        case (state_p0)
            ST_EMPTY: begin
                if (in_fire) state_nxt = ST_FULL;
            end
            ST_FULL: begin
                if (SKID_EN && in_fire && !out_ready) state_nxt = ST_SKIDDED;
                else if (!in_fire && out_fire)        state_nxt = ST_EMPTY;
            end
            ST_SKIDDED: begin
                if (out_fire) state_nxt = ST_FULL;
            end
            default: state_nxt = ST_EMPTY;
        endcase
        if (flush) state_nxt = ST_EMPTY;
    end

    always_comb begin
        load_in    = 1'b0;
        load_skid  = 1'b0;
        take_skid  = 1'b0;
        clear_main = (state_nxt == ST_EMPTY);
        if (!flush) begin
            load_in   = in_fire && ((state_p0 == ST_EMPTY) ||
                                    (state_p0 == ST_FULL && out_ready));
            load_skid = (state_p0 == ST_FULL) && (state_nxt == ST_SKIDDED);
            take_skid = (state_p0 == ST_SKIDDED) && (state_nxt == ST_FULL);
        end
    end

    // ---- main register: the only source of the outputs ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_p0 <= '0;
            data_p0 <= '0;
        end else if (clear_main) begin
            ctrl_p0 <= '0;
            if (CLR_EN) data_p0 <= '0;
        end else if (load_in) begin
            ctrl_p0 <= in_ctrl;
            data_p0 <= in_data;
        end else if (take_skid) begin
            ctrl_p0 <= skid_ctrl_p1;
            data_p0 <= skid_data_p1;
        end
    end

    // ---- skid entry: parks the word accepted while the head is blocked ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_ctrl_p1 <= '0;
            skid_data_p1 <= '0;
        end else if (load_skid) begin
            skid_ctrl_p1 <= in_ctrl;
            skid_data_p1 <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_p0 <= '0;
        end else if (cnt_clr) begin
            stall_p0 <= '0;
        end else if (vld_p0 && !out_ready) begin
            stall_p0 <= sat_inc(stall_p0);
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: a skid/clearing instance (CNT_W=4) and a single-entry/holding instance,
// checked every cycle against a counted-FIFO model plus directed literal expectations.
module tb_pipe_stage_buf;

    localparam int DW = 108;
    localparam int CW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          flush     [2];
    logic          in_valid  [2];
    logic          in_ready  [2];
    logic [CW-1:0] in_ctrl   [2];
    logic [DW-1:0] in_data   [2];
    logic          out_valid [2];
    logic          out_ready [2];
    logic [CW-1:0] out_ctrl  [2];
    logic [DW-1:0] out_data  [2];
    logic          cnt_clr   [2];
    logic [3:0]    stall_a;
    logic [15:0]   stall_b;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CLR_DATA(1), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .flush(flush[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_ctrl(in_ctrl[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_ctrl(out_ctrl[0]), .out_data(out_data[0]),
        .cnt_clr(cnt_clr[0]), .stall_cnt(stall_a)
    );

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CLR_DATA(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .flush(flush[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_ctrl(in_ctrl[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_ctrl(out_ctrl[1]), .out_data(out_data[1]),
        .cnt_clr(cnt_clr[1]), .stall_cnt(stall_b)
    );

    // Model: a FIFO of capacity m_cap holding {ctrl,data}, plus the last shown payload when empty.
    int            m_cap [2] = '{2, 1};
    bit            m_clr [2] = '{1'b1, 1'b0};
    int            m_max [2] = '{15, 65535};
    int            m_n   [2];
    int            m_stall [2];
    logic [CW-1:0] m_c [2][2];
    logic [DW-1:0] m_d [2][2];
    logic [DW-1:0] m_last [2];
    bit            pend [2];
    logic [CW-1:0] pc [2];
    logic [DW-1:0] pd [2];

    function automatic bit exp_ready(int i);
        if (m_cap[i] == 2) return (m_n[i] < 2);
        return (m_n[i] == 0) || out_ready[i];
    endfunction

    function automatic logic [DW-1:0] exp_data(int i);
        return (m_n[i] > 0) ? m_d[i][0] : m_last[i];
    endfunction

    function automatic logic [CW-1:0] exp_ctrl(int i);
        return (m_n[i] > 0) ? m_c[i][0] : '0;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int i = 0; i < 2; i++) begin
                    m_n[i] = 0; m_stall[i] = 0; m_last[i] = '0; pend[i] = 1'b0;
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    bit rdy, ifire, ofire;
                    rdy   = exp_ready(i);
                    ifire = in_valid[i] && rdy;
                    ofire = (m_n[i] > 0) && out_ready[i];
                    if (pend[i]) begin
                        n_cmp++;
                        if (!(in_valid[i] && in_data[i] == pd[i] && in_ctrl[i] == pc[i])) begin
                            n_bad++;
                            $display("FAIL upstream_hold[%0d]: input changed while stalled", i);
                        end
                    end
                    pend[i] = in_valid[i] && !rdy && !flush[i];
                    pd[i] = in_data[i];
                    pc[i] = in_ctrl[i];
                    if (cnt_clr[i]) m_stall[i] = 0;
                    else if (m_n[i] > 0 && !out_ready[i] && m_stall[i] < m_max[i]) m_stall[i]++;
                    if (flush[i]) begin
                        m_last[i] = m_clr[i] ? '0 : exp_data(i);
                        m_n[i] = 0;
                    end else begin
                        if (ofire) begin
                            m_last[i] = m_clr[i] ? '0 : m_d[i][0];
                            m_d[i][0] = m_d[i][1];
                            m_c[i][0] = m_c[i][1];
                            m_n[i]--;
                        end
                        if (ifire) begin
                            if (m_n[i] == 0) begin
                                m_d[i][0] = in_data[i]; m_c[i][0] = in_ctrl[i];
                            end else begin
                                m_d[i][1] = in_data[i]; m_c[i][1] = in_ctrl[i];
                            end
                            m_n[i]++;
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int i = 0; i < 2; i++) begin
                    chk(i == 0 ? "cyc_valid_a" : "cyc_valid_b", out_valid[i], m_n[i] > 0);
                    chk(i == 0 ? "cyc_ready_a" : "cyc_ready_b", in_ready[i], exp_ready(i));
                    chk(i == 0 ? "cyc_ctrl_a"  : "cyc_ctrl_b",  out_ctrl[i], exp_ctrl(i));
                    chk(i == 0 ? "cyc_data_a"  : "cyc_data_b",  out_data[i], exp_data(i));
                    chk(i == 0 ? "cyc_stall_a" : "cyc_stall_b",
                        (i == 0) ? 128'(stall_a) : 128'(stall_b), 128'(m_stall[i]));
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drv(input int i, input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_valid[i] = v;
        in_ctrl[i]  = c;
        in_data[i]  = d;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            flush[i] = 1'b0; out_ready[i] = 1'b0; cnt_clr[i] = 1'b0;
            drv(i, 1'b0, '0, '0);
        end
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("init_ready_a", in_ready[0], 1);
        chk("init_ready_b", in_ready[1], 1);
        chk("init_valid_a", out_valid[0], 0);

        // Streaming 1..100 with 1-cycle latency
        out_ready[0] = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            drv(0, 1'b1, CW'(k), DW'(k));
            tick();
            chk("stream_data", out_data[0], 128'(k));
            chk("stream_ready", in_ready[0], 1);
        end
        drv(0, 1'b0, '0, '0);
        tick();
        chk("drain_valid", out_valid[0], 0);
        chk("drain_data", out_data[0], 0);

        // Skid: A, B with downstream stalled, C waits until B drains
        out_ready[0] = 1'b0;
        drv(0, 1'b1, 8'h11, 'hA);
        tick();
        chk("skid_a_data", out_data[0], 'hA);
        drv(0, 1'b1, 8'h22, 'hB);
        tick();
        chk("skid_ready_low", in_ready[0], 0);
        chk("skid_a_ctrl", out_ctrl[0], 'h11);
        drv(0, 1'b1, 8'h33, 'hC);
        tick();
        chk("skid_hold_a", out_data[0], 'hA);
        chk("skid_stall2", stall_a, 2);
        out_ready[0] = 1'b1;
        tick();
        chk("skid_b_data", out_data[0], 'hB);
        chk("skid_b_ctrl", out_ctrl[0], 'h22);
        chk("skid_ready_back", in_ready[0], 1);
        tick();
        chk("skid_c_data", out_data[0], 'hC);
        chk("skid_c_ctrl", out_ctrl[0], 'h33);
        drv(0, 1'b0, '0, '0);
        tick();
        chk("skid_empty", out_valid[0], 0);
        cnt_clr[0] = 1'b1;
        tick();
        cnt_clr[0] = 1'b0;
        chk("skid_cnt_clr", stall_a, 0);

        // Flush while SKIDDED, with C offered in the same cycle
        out_ready[0] = 1'b0;
        drv(0, 1'b1, 8'h41, 'h1A1);
        tick();
        drv(0, 1'b1, 8'h42, 'h1B2);
        tick();
        chk("flush_pre_ready", in_ready[0], 0);
        drv(0, 1'b1, 8'h43, 'h1C3);
        flush[0] = 1'b1;
        tick();
        flush[0] = 1'b0;
        drv(0, 1'b0, '0, '0);
        chk("flush_valid", out_valid[0], 0);
        chk("flush_ctrl", out_ctrl[0], 0);
        chk("flush_data", out_data[0], 0);
        chk("flush_ready", in_ready[0], 1);
        out_ready[0] = 1'b1;
        repeat (3) begin
            tick();
            chk("flush_no_c", out_valid[0], 0);
        end
        chk("flush_keeps_stall", stall_a, 2);
        cnt_clr[0] = 1'b1;
        tick();
        cnt_clr[0] = 1'b0;

        // Stall counter: 5 cycles, saturation at 15, clear beats increment
        out_ready[0] = 1'b0;
        drv(0, 1'b1, 8'h51, 'h5A);
        tick();
        drv(0, 1'b0, '0, '0);
        repeat (5) tick();
        chk("cnt_5", stall_a, 5);
        repeat (15) tick();
        chk("cnt_sat", stall_a, 15);
        cnt_clr[0] = 1'b1;
        tick();
        cnt_clr[0] = 1'b0;
        chk("cnt_clr_wins", stall_a, 0);
        tick();
        chk("cnt_restart", stall_a, 1);
        out_ready[0] = 1'b1;
        tick();
        chk("cnt_drain", out_valid[0], 0);

        // Asynchronous reset in SKIDDED
        out_ready[0] = 1'b0;
        drv(0, 1'b1, 8'h61, 'h6A);
        tick();
        drv(0, 1'b1, 8'h62, 'h6B);
        tick();
        drv(0, 1'b0, '0, '0);
        chk("rst_pre_ready", in_ready[0], 0);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", out_valid[0], 0);
        chk("arst_ctrl", out_ctrl[0], 0);
        chk("arst_data", out_data[0], 0);
        chk("arst_stall", stall_a, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_ready", in_ready[0], 1);
        chk("arst_still_empty", out_valid[0], 0);

        // Single entry, payload held on drain/flush
        out_ready[1] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            drv(1, 1'b1, CW'(k), DW'(256 + k));
            tick();
            chk("b_stream_data", out_data[1], 128'(256 + k));
        end
        drv(1, 1'b0, '0, '0);
        tick();
        chk("b_drain_valid", out_valid[1], 0);
        chk("b_drain_held", out_data[1], 'h103);
        chk("b_drain_ctrl", out_ctrl[1], 0);
        out_ready[1] = 1'b0;
        drv(1, 1'b1, 8'h71, 'hD0D);
        tick();
        drv(1, 1'b0, '0, '0);
        chk("b_full_valid", out_valid[1], 1);
        chk("b_ready_comb_low", in_ready[1], 0);
        out_ready[1] = 1'b1;
        #1 chk("b_ready_comb_high", in_ready[1], 1);
        out_ready[1] = 1'b0;
        #1 chk("b_ready_comb_low2", in_ready[1], 0);
        tick();
        chk("b_held_data", out_data[1], 'hD0D);
        chk("b_stall1", stall_b, 1);
        drv(1, 1'b1, 8'h72, 'hE0E);
        tick();
        flush[1] = 1'b1;
        tick();
        flush[1] = 1'b0;
        drv(1, 1'b0, '0, '0);
        chk("b_flush_valid", out_valid[1], 0);
        chk("b_flush_ctrl", out_ctrl[1], 0);
        chk("b_flush_data_kept", out_data[1], 'hD0D);
        chk("b_flush_ready", in_ready[1], 1);
        chk("b_flush_stall", stall_b, 3);
        out_ready[1] = 1'b1;
        tick();
        chk("b_no_e", out_valid[1], 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
